// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB master. One accepted command on the valid/ready
//   interface produces exactly one APB SETUP/ACCESS transfer and one
//   single-cycle response pulse. All outputs are registered.
//
//   Optional feature macro: APB_MASTER_TIMEOUT_EN
//     defined   - ACCESS is aborted with rsp_err=1 after TIMEOUT_CYCLES
//                 consecutive PREADY-low cycles
//     undefined - ACCESS waits indefinitely for PREADY, rsp_err stays 0
//
// Ports
//   PCLK, PRESET        clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_write/addr/wdata command direction, address, write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata/rsp_err   read data (0 for writes/errors), timeout flag
//   PSEL..PWDATA        APB request pins
//   PRDATA, PREADY      APB completion pins

module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_nx;
  logic                  cmd_ready_nx, rsp_valid_nx, rsp_err_nx;
  logic                  psel_nx, penable_nx, pwrite_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx, rsp_rdata_nx;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_nx;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nx;
      cmd_ready <= cmd_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      PSEL      <= psel_nx;
      PENABLE   <= penable_nx;
      PWRITE    <= pwrite_nx;
      PADDR     <= paddr_nx;
      PWDATA    <= pwdata_nx;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt       <= cnt_nx;
`endif
    end
  end

  // Next-value logic for every registered output; the outputs therefore
  // describe the state being entered, not the state being left.
  always_comb begin
    state_nx     = state;
    cmd_ready_nx = cmd_ready;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    psel_nx      = PSEL;
    penable_nx   = PENABLE;
    pwrite_nx    = PWRITE;
    paddr_nx     = PADDR;
    pwdata_nx    = PWDATA;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_nx       = cnt;
`endif

    unique case (state)
      IDLE: begin
        cmd_ready_nx = 1'b1;
        // cmd_ready is a register: it is low in the first cycle after reset
        if (cmd_valid && cmd_ready) begin
          state_nx     = SETUP;
          cmd_ready_nx = 1'b0;
          psel_nx      = 1'b1;
          pwrite_nx    = cmd_write;
          paddr_nx     = cmd_addr;
          pwdata_nx    = cmd_write ? cmd_wdata : '0;
        end
      end

      SETUP: begin
        state_nx   = ACCESS;
        penable_nx = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_nx     = '0;
`endif
      end

      ACCESS: begin
        if (PREADY) begin
          state_nx     = IDLE;
          cmd_ready_nx = 1'b1;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = PWRITE ? '0 : PRDATA;
          rsp_err_nx   = 1'b0;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          pwrite_nx    = 1'b0;
          paddr_nx     = '0;
          pwdata_nx    = '0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          state_nx     = IDLE;
          cmd_ready_nx = 1'b1;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b1;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          pwrite_nx    = 1'b0;
          paddr_nx     = '0;
          pwdata_nx    = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with a 1024-word APB memory slave
//   model. PREADY is generated from a programmable wait-state count or held
//   low to stall. Build with +define+APB_MASTER_TIMEOUT_EN to exercise the
//   timeout abort (TIMEOUT_CYCLES=4).

module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif
  localparam int NRAND = 12;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY;

  int tests = 0;
  int fails = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  // Memory slave model
  logic [DW-1:0] mem [0:1023];
  int unsigned   acc_cnt = 0;
  int unsigned   wait_states = 0;
  logic          stall_forever = 1'b0;

  assign PRDATA = mem[PADDR[9:0]];
  assign PREADY = !stall_forever && (acc_cnt >= wait_states);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[9:0]] <= PWDATA;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one command (caller guarantees cmd_ready=1) and wait, bounded, for
  // its response. Reports ACCESS cycle count, SETUP cycle count and pulses.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic hold, output logic [DW-1:0] rd, output logic er,
                      output int acc, output int setups, output int pulses,
                      output int addr_bad);
    logic done;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    if (!hold) cmd_valid = 1'b0;
    acc = 0; setups = 0; pulses = 0; addr_bad = 0; done = 1'b0;
    rd = '0; er = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (PSEL && PADDR !== a) addr_bad++;
      if (PSEL && PENABLE) acc++;
      if (PSEL && !PENABLE) setups++;
      if (rsp_valid) begin
        pulses++;
        rd   = rsp_rdata;
        er   = rsp_err;
        done = 1'b1;
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;
    if (!done) check("rsp_wait_bound", 0, 1);
    step();
    if (rsp_valid) pulses++;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            acc, setups, pulses, addr_bad, bad, passes;
  logic [AW-1:0] raddr [NRAND];
  logic [DW-1:0] rdat  [NRAND];
  int unsigned   base;

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;

    // Reset held two cycles
    step();
    check("rst1_psel", PSEL, 0);
    step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_psel",      PSEL, 0);
    check("rst_penable",   PENABLE, 0);
    check("rst_pwrite",    PWRITE, 0);
    check("rst_paddr",     PADDR, 0);
    check("rst_pwdata",    PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err, 0);
    PRESET = 1'b0;
    step();
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_psel",      PSEL, 0);

    // Directed write, zero wait states, cycle by cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3FF; cmd_wdata = 32'hDEADBEEF;
    step();
    cmd_valid = 1'b0;
    check("w_n1_psel",      PSEL, 1);
    check("w_n1_penable",   PENABLE, 0);
    check("w_n1_pwrite",    PWRITE, 1);
    check("w_n1_paddr",     PADDR, 32'h3FF);
    check("w_n1_pwdata",    PWDATA, 32'hDEADBEEF);
    check("w_n1_cmd_ready", cmd_ready, 0);
    step();
    check("w_n2_psel",      PSEL, 1);
    check("w_n2_penable",   PENABLE, 1);
    check("w_n2_paddr",     PADDR, 32'h3FF);
    check("w_n2_pwdata",    PWDATA, 32'hDEADBEEF);
    check("w_n2_rsp_valid", rsp_valid, 0);
    step();
    check("w_n3_rsp_valid", rsp_valid, 1);
    check("w_n3_rsp_err",   rsp_err, 0);
    check("w_n3_rsp_rdata", rsp_rdata, 0);
    check("w_n3_cmd_ready", cmd_ready, 1);
    check("w_n3_psel",      PSEL, 0);
    check("w_n3_penable",   PENABLE, 0);
    check("w_n3_paddr",     PADDR, 0);
    check("w_n3_pwdata",    PWDATA, 0);
    step();
    check("w_n4_rsp_valid", rsp_valid, 0);
    check("w_mem_3ff",      mem[10'h3FF], 32'hDEADBEEF);

    // Read back 0x3FF
    xfer(1'b0, 32'h3FF, '0, 1'b0, rd, er, acc, setups, pulses, addr_bad);
    check("r3ff_rdata",  rd, 32'hDEADBEEF);
    check("r3ff_err",    er, 0);
    check("r3ff_access", acc, 1);
    check("r3ff_pulses", pulses, 1);

    // Read with 3 wait states, cmd_valid held throughout
    xfer(1'b1, 32'h5, 32'h12345678, 1'b0, rd, er, acc, setups, pulses, addr_bad);
    wait_states = 3;
    xfer(1'b0, 32'h5, '0, 1'b1, rd, er, acc, setups, pulses, addr_bad);
    wait_states = 0;
    check("ws_rdata",    rd, 32'h12345678);
    check("ws_err",      er, 0);
    check("ws_access",   acc, 4);
    check("ws_setups",   setups, 1);
    check("ws_pulses",   pulses, 1);
    check("ws_addr",     addr_bad, 0);
    check("ws_idle_rdy", cmd_ready, 1);

    // Reset during ACCESS
    stall_forever = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
    step();
    cmd_valid = 1'b0;
    step();
    check("ab_in_access", PSEL && PENABLE, 1);
    PRESET = 1'b1;
    step();
    check("ab_psel",      PSEL, 0);
    check("ab_penable",   PENABLE, 0);
    check("ab_rsp_valid", rsp_valid, 0);
    PRESET = 1'b0; stall_forever = 1'b0;
    step();
    check("ab_rel_ready", cmd_ready, 1);
    check("ab_rel_rsp",   rsp_valid, 0);
    xfer(1'b0, 32'h5, '0, 1'b0, rd, er, acc, setups, pulses, addr_bad);
    check("ab_next_rdata",  rd, 32'h12345678);
    check("ab_next_pulses", pulses, 1);

`ifdef APB_MASTER_TIMEOUT_EN
    stall_forever = 1'b1;
    xfer(1'b0, 32'h5, '0, 1'b0, rd, er, acc, setups, pulses, addr_bad);
    stall_forever = 1'b0;
    check("to_access", acc, 4);
    check("to_err",    er, 1);
    check("to_rdata",  rd, 0);
    check("to_pulses", pulses, 1);
    check("to_psel",   PSEL, 0);
    check("to_ready",  cmd_ready, 1);
`else
    stall_forever = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
    step();
    cmd_valid = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(PSEL && PENABLE) || rsp_valid || rsp_err) bad++;
      step();
    end
    check("nto_stuck_bad", bad, 0);
    check("nto_in_access", PSEL && PENABLE, 1);
    PRESET = 1'b1; step();
    PRESET = 1'b0; stall_forever = 1'b0; step();
    check("nto_recover_ready", cmd_ready, 1);
`endif

    // Random writes then read-back
    base = $urandom_range(0, 1023);
    for (int i = 0; i < NRAND; i++) begin
      raddr[i] = AW'((base + 85 * i) % 1024);
      rdat[i]  = $urandom;
      xfer(1'b1, raddr[i], rdat[i], 1'b0, rd, er, acc, setups, pulses, addr_bad);
      check("rw_rdata_zero", rd, 0);
      check("rw_err",        er, 0);
    end
    passes = 0;
    for (int i = 0; i < NRAND; i++) begin
      xfer(1'b0, raddr[i], '0, 1'b0, rd, er, acc, setups, pulses, addr_bad);
      check("rb_rdata", rd, rdat[i]);
      if (rd === rdat[i] && pulses == 1) passes++;
    end
    check("rb_pass_count", passes, NRAND);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers. It sits directly upstream of the team's APB memory slave (32-bit data, 1024-word address space) and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA pins. Each accepted command produces exactly one APB transfer and exactly one one-cycle response pulse carrying read data and an error flag.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/PADDR
- DATA_WIDTH, 32, width of write/read data
- TIMEOUT_CYCLES, 16, PREADY-low cycles tolerated in ACCESS (used only with timeout feature)

Ports:
- PCLK  input  1  clock, all logic on rising edge
- PRESET  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  bridge can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  output  1  transfer timed out
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  ADDR_WIDTH  APB address
- PWDATA  output  DATA_WIDTH  APB write data
- PRDATA  input  DATA_WIDTH  APB read data
- PREADY  input  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0, PWRITE/PADDR/PWDATA=0. On edge with cmd_valid&&cmd_ready: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA (PWDATA=0 for reads), PSEL<=1, go SETUP.
- SETUP: cmd_ready=0, PSEL=1, PENABLE=0. Unconditionally next edge: PENABLE<=1, go ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE held stable. On edge with PREADY=1: capture PRDATA into rsp_rdata (reads) or 0 (writes), rsp_valid<=1, rsp_err<=0, clear PSEL/PENABLE/PWRITE/PADDR/PWDATA, go IDLE.
- PREADY=0 in ACCESS: stay (wait state); timeout behaviour per Configuration.
- PREADY ignored outside ACCESS.
- cmd_valid while cmd_ready=0: ignored, no side effects; requester must hold cmd stable until accepted.
- rsp_valid is high for exactly one cycle per accepted command; no backpressure on response.
- Reset: synchronous; at the edge with PRESET=1 every output goes to 0 (cmd_ready included), FSM to IDLE, timeout counter to 0. cmd_ready rises at the first edge with PRESET=0. Reset during SETUP/ACCESS aborts the transfer with no response pulse.

## Timing
- Accept edge N → SETUP visible cycle N+1 → ACCESS cycle N+2.
- Zero wait states: PREADY=1 sampled at edge N+3; rsp_valid and cmd_ready high in cycle N+3.
- k wait states: ACCESS lasts k+1 cycles; rsp_valid k cycles later.
- Maximum throughput: one transfer per 3 cycles (accept in IDLE cycle is same cycle rsp_valid is shown).
- rsp_rdata/rsp_err valid only while rsp_valid=1; hold last value otherwise.

## Configuration
- Macro APB_MASTER_TIMEOUT_EN.
- Defined: 0-based counter cleared on entry to ACCESS, increments each ACCESS cycle with PREADY=0. When the counter equals TIMEOUT_CYCLES-1 and PREADY=0, next edge aborts: PSEL/PENABLE/PADDR/PWDATA/PWRITE cleared, rsp_valid=1, rsp_err=1, rsp_rdata=0, FSM to IDLE. PREADY=1 on that same edge wins (normal completion, rsp_err=0).
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied to 0.

## Test plan
- Reset held 2 cycles, release → all outputs 0 during reset; cmd_ready=1 first cycle after release; PSEL never asserted.
- Write addr 0x3FF data 0xDEADBEEF, PREADY tied 1 → PSEL at N+1, PENABLE at N+2, PADDR=0x3FF/PWDATA=0xDEADBEEF stable N+1..N+2, rsp_valid one cycle at N+3, rsp_err=0; then read 0x3FF → rsp_rdata=0xDEADBEEF.
- Read with PREADY low 3 cycles then high, PRDATA=0x12345678 → ACCESS lasts 4 cycles, rsp_rdata=0x12345678, exactly one rsp_valid pulse; cmd_valid held during transfer not accepted until IDLE.
- PRESET asserted during ACCESS → PSEL/PENABLE 0 next cycle, no rsp_valid, next command completes normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 → abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; without macro, bridge still in ACCESS after 100 cycles.
- 6-20 random writes (addr 0-1023, random data) then read-back of each against the memory slave → every rsp_rdata matches the written data, pass count equals command count.
